// File: rtl/pad_serializer_pkg.sv
// rtl/pad_serializer_pkg.sv - shared button indices, FSM states and keycode defaults for pad_serializer
package pad_serializer_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam logic [7:0] DEF_KEY_A      = 8'h1B;
  localparam logic [7:0] DEF_KEY_B      = 8'h1D;
  localparam logic [7:0] DEF_KEY_SELECT = 8'h2B;
  localparam logic [7:0] DEF_KEY_START  = 8'h28;
  localparam logic [7:0] DEF_KEY_UP     = 8'h52;
  localparam logic [7:0] DEF_KEY_DOWN   = 8'h51;
  localparam logic [7:0] DEF_KEY_LEFT   = 8'h50;
  localparam logic [7:0] DEF_KEY_RIGHT  = 8'h4F;

  typedef enum logic {
    LOAD  = 1'b0,
    SHIFT = 1'b1
  } pad_state_t;

  // True when any of the four packed slots holds key; an empty slot (8'h00) never counts.
  function automatic logic key_hit(input logic [31:0] slots, input logic [7:0] key);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ((slots[i*8 +: 8] != 8'h00) && (slots[i*8 +: 8] == key)) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/pad_serializer_sync_edge.sv
// rtl/pad_serializer_sync_edge.sv - two-flop synchronizer with a third flop for edge detection
module pad_serializer_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  // Bring the asynchronous port signal into clk and keep one extra stage of history.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 && !s3;
  assign fall  = !s2 && s3;

endmodule

// File: rtl/pad_serializer.sv
// rtl/pad_serializer.sv - NES controller emulation: HID keycodes to 4021-style serial pad
module pad_serializer
  import pad_serializer_pkg::*;
#(
  parameter logic [7:0] KEY_A      = DEF_KEY_A,
  parameter logic [7:0] KEY_B      = DEF_KEY_B,
  parameter logic [7:0] KEY_SELECT = DEF_KEY_SELECT,
  parameter logic [7:0] KEY_START  = DEF_KEY_START,
  parameter logic [7:0] KEY_UP     = DEF_KEY_UP,
  parameter logic [7:0] KEY_DOWN   = DEF_KEY_DOWN,
  parameter logic [7:0] KEY_LEFT   = DEF_KEY_LEFT,
  parameter logic [7:0] KEY_RIGHT  = DEF_KEY_RIGHT,
  parameter int         TURBO_DIV  = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] keycodes,
  input  logic [1:0]  turbo_en,
  input  logic        pad_latch,
  input  logic        pad_clk,
  output logic        pad_data,
  output logic [7:0]  buttons
);

  logic [7:0]           pressed;
  logic [7:0]           btn_next;
  logic [TURBO_DIV-1:0] turbo_cnt;
  logic                 turbo_phase;

  logic       latch_s;
  logic       latch_rise_unused;
  logic       latch_fall;
  logic       clk_level_unused;
  logic       clk_rise;
  logic       clk_fall_unused;

  pad_state_t state;
  pad_state_t state_next;
  logic [7:0] shift_reg;
  logic [7:0] shift_next;
  logic [3:0] bit_cnt;
  logic [3:0] cnt_next;
  logic       data_next;

  assign turbo_phase = turbo_cnt[TURBO_DIV-1];

  // Decode keycodes into raw buttons, cancel opposing directions, then apply turbo gating.
  always_comb begin
    pressed             = 8'h00;
    pressed[BTN_A]      = key_hit(keycodes, KEY_A);
    pressed[BTN_B]      = key_hit(keycodes, KEY_B);
    pressed[BTN_SELECT] = key_hit(keycodes, KEY_SELECT);
    pressed[BTN_START]  = key_hit(keycodes, KEY_START);
    pressed[BTN_UP]     = key_hit(keycodes, KEY_UP);
    pressed[BTN_DOWN]   = key_hit(keycodes, KEY_DOWN);
    pressed[BTN_LEFT]   = key_hit(keycodes, KEY_LEFT);
    pressed[BTN_RIGHT]  = key_hit(keycodes, KEY_RIGHT);
    btn_next = pressed;
    if (pressed[BTN_UP] && pressed[BTN_DOWN]) begin
      btn_next[BTN_UP]   = 1'b0;
      btn_next[BTN_DOWN] = 1'b0;
    end
    if (pressed[BTN_LEFT] && pressed[BTN_RIGHT]) begin
      btn_next[BTN_LEFT]  = 1'b0;
      btn_next[BTN_RIGHT] = 1'b0;
    end
    if (turbo_en[0]) btn_next[BTN_A] = pressed[BTN_A] && turbo_phase;
    if (turbo_en[1]) btn_next[BTN_B] = pressed[BTN_B] && turbo_phase;
  end

  // Live button register and free-running turbo phase counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      buttons   <= 8'h00;
      turbo_cnt <= '0;
    end else begin
      buttons   <= btn_next;
      turbo_cnt <= turbo_cnt + {{(TURBO_DIV-1){1'b0}}, 1'b1};
    end
  end

  pad_serializer_sync_edge u_latch_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (pad_latch),
    .level (latch_s),
    .rise  (latch_rise_unused),
    .fall  (latch_fall)
  );

  pad_serializer_sync_edge u_clk_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (pad_clk),
    .level (clk_level_unused),
    .rise  (clk_rise),
    .fall  (clk_fall_unused)
  );

  // Shifter next state: a high latch always reloads and wins over a coincident shift pulse.
  always_comb begin
    state_next = state;
    shift_next = shift_reg;
    cnt_next   = bit_cnt;
    data_next  = pad_data;
    if (latch_s) begin
      state_next = LOAD;
      shift_next = buttons;
      cnt_next   = 4'd0;
      data_next  = buttons[BTN_A];
    end else begin
      case (state)
        LOAD: begin
          if (latch_fall) state_next = SHIFT;
        end
        SHIFT: begin
          if (clk_rise && (bit_cnt != 4'd8)) begin
            shift_next = {1'b1, shift_reg[7:1]};
            cnt_next   = bit_cnt + 4'd1;
            data_next  = shift_reg[1];
          end
        end
        default: state_next = LOAD;
      endcase
    end
  end

  // Shifter state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      shift_reg <= 8'h00;
      bit_cnt   <= 4'd0;
      pad_data  <= 1'b0;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      bit_cnt   <= cnt_next;
      pad_data  <= data_next;
    end
  end

endmodule

// File: tb/tb_pad_serializer.sv
// tb/tb_pad_serializer.sv - directed self-checking bench for pad_serializer
module tb_pad_serializer;
  import pad_serializer_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] keycodes;
  logic [1:0]  turbo_en;
  logic        pad_latch;
  logic        pad_clk;
  logic        pad_data;
  logic [7:0]  buttons;

  int n_assert = 0;
  int n_fail   = 0;

  pad_serializer #(.TURBO_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .keycodes  (keycodes),
    .turbo_en  (turbo_en),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .pad_data  (pad_data),
    .buttons   (buttons)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_latch();
    pad_latch = 1'b1;
    step(4);
    pad_latch = 1'b0;
    step(3);
  endtask

  task automatic pulse();
    pad_clk = 1'b1;
    step(2);
    pad_clk = 1'b0;
    step(2);
  endtask

  // Reads a full report plus two extra pulses; bits past the eighth must read as 1.
  task automatic read_report(input string tag, input logic [7:0] exp);
    check($sformatf("%s_bit0", tag), {31'b0, pad_data}, {31'b0, exp[0]});
    for (int j = 1; j <= 10; j++) begin
      pulse();
      check($sformatf("%s_bit%0d", tag, j), {31'b0, pad_data},
            {31'b0, (j < 8) ? exp[j] : 1'b1});
    end
    check($sformatf("%s_cnt", tag), {28'b0, dut.bit_cnt}, 32'd8);
  endtask

  initial begin
    logic v;
    logic seen;
    rst       = 1'b1;
    keycodes  = 32'h0;
    turbo_en  = 2'b00;
    pad_latch = 1'b0;
    pad_clk   = 1'b0;
    step(3);
    check("rst_pad_data", {31'b0, pad_data}, 32'd0);
    check("rst_buttons", {24'b0, buttons}, 32'd0);
    check("rst_cnt", {28'b0, dut.bit_cnt}, 32'd0);
    check("rst_shift", {24'b0, dut.shift_reg}, 32'd0);
    rst = 1'b0;

    // A only: latency of buttons, latch and pad_clk, then the serial sequence.
    keycodes = 32'h0000_001B;
    step(1);
    check("a_buttons", {24'b0, buttons}, 32'h01);
    pad_latch = 1'b1;
    step(2);
    check("latch_lat_early", {31'b0, pad_data}, 32'd0);
    step(1);
    check("latch_lat", {31'b0, pad_data}, 32'd1);
    step(1);
    pad_latch = 1'b0;
    step(3);
    check("a_bit0", {31'b0, pad_data}, 32'd1);
    pad_clk = 1'b1;
    step(2);
    check("clk_lat_early", {31'b0, pad_data}, 32'd1);
    step(1);
    check("clk_lat", {31'b0, pad_data}, 32'd0);
    pad_clk = 1'b0;
    step(1);
    for (int j = 2; j <= 10; j++) begin
      pulse();
      check($sformatf("a_bit%0d", j), {31'b0, pad_data}, {31'b0, (j >= 8)});
    end
    check("a_cnt_sat", {28'b0, dut.bit_cnt}, 32'd8);

    // Right, Start, B, Up.
    keycodes = 32'h4F28_1D52;
    step(1);
    check("mix_buttons", {24'b0, buttons}, 32'h9A);
    do_latch();
    read_report("mix", 8'h9A);

    // Opposing directions cancel.
    keycodes = 32'h0000_5251;
    step(1);
    check("socd_ud", {30'b0, buttons[5:4]}, 32'd0);
    keycodes = 32'h0000_504F;
    step(1);
    check("socd_lr", {30'b0, buttons[7:6]}, 32'd0);
    keycodes = 32'h0052_4F50;
    step(1);
    check("socd_up_kept", {24'b0, buttons}, 32'h10);
    keycodes = 32'h0000_0000;
    step(1);
    check("empty_buttons", {24'b0, buttons}, 32'h00);

    // Turbo on A with a 4-bit counter: half period of 8 cycles, B steady.
    keycodes = 32'h0000_1D1B;
    turbo_en = 2'b01;
    step(1);
    v = buttons[0];
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1);
      if (buttons[0] !== v) seen = 1'b1;
    end
    check("turbo_edge_seen", {31'b0, seen}, 32'd1);
    v = buttons[0];
    for (int h = 0; h < 2; h++) begin
      for (int i = 1; i < 8; i++) begin
        step(1);
        check($sformatf("turbo_hold%0d_%0d", h, i), {31'b0, buttons[0]}, {31'b0, v});
        check($sformatf("turbo_b%0d_%0d", h, i), {31'b0, buttons[1]}, 32'd1);
      end
      step(1);
      check($sformatf("turbo_toggle%0d", h), {31'b0, buttons[0]}, {31'b0, ~v});
      v = ~v;
    end
    turbo_en = 2'b00;

    // Key change mid-report does not disturb the in-flight bits.
    keycodes = 32'h0000_001B;
    step(1);
    do_latch();
    check("chg_bit0", {31'b0, pad_data}, 32'd1);
    pulse();
    check("chg_bit1", {31'b0, pad_data}, 32'd0);
    keycodes = 32'h0000_001D;
    for (int j = 2; j < 8; j++) begin
      pulse();
      check($sformatf("chg_bit%0d", j), {31'b0, pad_data}, 32'd0);
    end
    check("chg_buttons", {24'b0, buttons}, 32'h02);
    do_latch();
    check("chg_next_bit0", {31'b0, pad_data}, 32'd0);
    pulse();
    check("chg_next_bit1", {31'b0, pad_data}, 32'd1);
    pulse();
    check("chg_next_bit2", {31'b0, pad_data}, 32'd0);

    // Latch and pad_clk rising together: latch wins.
    keycodes = 32'h0000_001B;
    step(1);
    do_latch();
    pulse();
    check("col_pre_data", {31'b0, pad_data}, 32'd0);
    check("col_pre_cnt", {28'b0, dut.bit_cnt}, 32'd1);
    pad_latch = 1'b1;
    pad_clk   = 1'b1;
    step(3);
    check("col_data", {31'b0, pad_data}, 32'd1);
    check("col_cnt", {28'b0, dut.bit_cnt}, 32'd0);
    check("col_shift", {24'b0, dut.shift_reg}, 32'h01);
    step(1);
    pad_latch = 1'b0;
    pad_clk   = 1'b0;
    step(4);
    pulse();
    pulse();
    check("mid_data", {31'b0, pad_data}, 32'd0);
    check("mid_cnt", {28'b0, dut.bit_cnt}, 32'd2);

    // Reset mid-shift zeroes everything; pad_clk is ignored until a latch.
    rst = 1'b1;
    step(1);
    check("rst2_data", {31'b0, pad_data}, 32'd0);
    check("rst2_cnt", {28'b0, dut.bit_cnt}, 32'd0);
    check("rst2_shift", {24'b0, dut.shift_reg}, 32'd0);
    check("rst2_buttons", {24'b0, buttons}, 32'd0);
    check("rst2_state", {31'b0, dut.state}, {31'b0, LOAD});
    rst = 1'b0;
    step(1);
    check("post_rst_buttons", {24'b0, buttons}, 32'h01);
    pulse();
    check("post_rst_clk_ignored", {31'b0, pad_data}, 32'd0);
    check("post_rst_cnt", {28'b0, dut.bit_cnt}, 32'd0);
    do_latch();
    check("post_rst_bit0", {31'b0, pad_data}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pad_serializer.md
Name: pad_serializer

Overview:
- Emulates a standard NES controller on the controller-port side. It is the responder to the controller-port reader driven by the CPU at $4016/$4017.
- Converts USB keycodes from the MicroBlaze GPIO into an 8-button state and presents it as a 4021-style parallel-in/serial-out shift register.
- Inputs are the pad latch (strobe) and pad clock pulses; output is the serial data bit.
- One instance per player, clocked from clk_CPU.

Parameters:
- KEY_A, 8'h1B, USB HID code for A (X key)
- KEY_B, 8'h1D, HID code for B (Z key)
- KEY_SELECT, 8'h2B, HID code for Select (Tab)
- KEY_START, 8'h28, HID code for Start (Enter)
- KEY_UP / KEY_DOWN / KEY_LEFT / KEY_RIGHT, 8'h52 / 8'h51 / 8'h50 / 8'h4F, arrow keys
- TURBO_DIV, 18, turbo toggle period exponent: rate = clk / 2^TURBO_DIV

Ports:
- clk  in  1  system clock (clk_CPU domain)
- rst  in  1  synchronous, active-high reset
- keycodes  in  32  four packed HID keycodes, byte 0 in [7:0], 8'h00 = empty slot
- turbo_en  in  2  bit0 = turbo on A, bit1 = turbo on B
- pad_latch  in  1  strobe from port, high = parallel load (asynchronous to clk)
- pad_clk  in  1  shift pulse from port, shift on rising edge (asynchronous to clk)
- pad_data  out  1  serial bit, 1 = pressed (inversion is done by the reader)
- buttons  out  8  registered live button state {Right,Left,Down,Up,Start,Select,B,A}, for debug/hex display

Behaviour:
- Reset: shift reg = 8'h00, bit counter = 0, buttons = 0, pad_data = 0, sync flops = 0, turbo counter = 0.
- Key decode:
  - Combinational compare of each button's keycode against all 4 slots.
  - The result is registered into buttons every clk, so latency from keycodes to buttons is 1 cycle.
  - 8'h00 never matches any button.
- SOCD cleaning, applied before the buttons register:
  - Up && Down both pressed -> both cleared.
  - Left && Right both pressed -> both cleared.
- Turbo:
  - Free-running TURBO_DIV-bit counter; its MSB is the turbo phase.
  - If turbo_en[i] is set, the corresponding A/B bit = pressed && phase.
- Synchronizers:
  - pad_latch and pad_clk each pass through a 2-flop synchronizer, plus a third flop for rising-edge detect.
  - clk_rise = s2 && !s3.
- Shift state machine: two states, LOAD and SHIFT.
  - LOAD (latch_s high): each cycle shift reg <= buttons, count <= 0, pad_data <= buttons[0] (A). pad_clk edges are ignored.
  - LOAD -> SHIFT on latch_s falling. The shift reg holds the last loaded value.
  - SHIFT, on clk_rise: shift reg <= {1'b1, shift reg[7:1]}; count saturates at 8; pad_data <= new shift reg[0].
  - After 8 shifts pad_data is held at 1. This matches official pads, which return 1 after the 8th read.
  - SHIFT -> LOAD on latch_s high.
- Latency:
  - pad_clk rising at the pin -> pad_data updated 3 clk cycles later.
  - pad_latch rising -> A bit on pad_data 3 cycles later.
- Simultaneous latch high and clk_rise: latch wins, so the shift is suppressed.
- Key changes during SHIFT do not affect the in-flight report; they take effect on the next latch.
- Reset mid-shift returns to LOAD semantics once latch_s is sampled, with all state zeroed.

Decomposition:
- Shared package PadPkg:
  - Button index constants BTN_A=0 … BTN_RIGHT=7.
  - typedef pad_state_t (enum LOAD, SHIFT).
  - Default keycode localparams.
- Natural sub-module: sync_edge (2-flop synchronizer + rising/falling edge detect), instantiated twice.

Test Plan:
- Reset, keycodes=32'h0000_001B, latch high 4 cycles then low, 8 pad_clk pulses -> pad_data sequence 1,0,0,0,0,0,0,0; pulses 9–10 -> 1,1.
- keycodes=32'h4F28_1D52 (Right, Start, B, Up), single latch/8 clocks -> buttons=8'h9A; serial bits 0,1,0,1,1,0,0,1.
- keycodes=32'h0000_5251 (Up+Down) -> buttons[5:4]=2'b00; with 32'h0000_504F (Left+Right) -> buttons[7:6]=2'b00.
- TURBO_DIV=4, turbo_en=2'b01, A held -> buttons[0] toggles every 8 cycles; B, with turbo off, is held steady.
- Change keycodes from A to B after latch, before the 2nd pad_clk -> the report still shows A only; the next latch shows B only.
- Assert latch and a pad_clk rising edge in the same cycle, then assert rst mid-shift -> no shift on the collision; after rst, pad_data=0 and count=0.
